// File: rtl/ddr_avl_arbiter.sv
// ddr_avl_arbiter
// Shares one DDR3 Avalon-MM user port between the ADC sample logger (write
// requester) and the alarm readback engine (read requester). Writes have
// priority; after WR_MAX consecutive write grants with a read pending, the
// read is forced through. Only one burst is ever outstanding.
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   enable, init_done           arbitration enable (IDLE only), calibration done
//   wr_req/wr_addr/wr_data0/1   write burst request, held until wr_ack
//   wr_ack                      pulse: beat 1 accepted by the controller
//   rd_req/rd_addr              read burst request, held until rd_ack
//   rd_ack                      pulse: read command accepted
//   rd_data/rd_valid/rd_done    returned beats, final-beat marker
//   rd_err                      pulse: read data did not arrive in time
//   avl_*                       Avalon-MM master toward the memory controller
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no burst outstanding; arbitrate when enable & init_done
// ST_WR_B0   | write beat 0 (timestamp) presented with beginbursttransfer
// ST_WR_B1   | write beat 1 (ADC channel word) presented
// ST_RD_CMD  | read command presented, waiting for avl_ready
// ST_RD_WAIT | collecting read beats, timeout counter running
module ddr_avl_arbiter #(
  parameter int WR_MAX     = 8,
  parameter int RD_TIMEOUT = 1023,
  parameter int BURST_LEN  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        init_done,
  input  logic        wr_req,
  input  logic [24:0] wr_addr,
  input  logic [63:0] wr_data0,
  input  logic [63:0] wr_data1,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic        rd_ack,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        rd_err,
  output logic [24:0] avl_address,
  output logic        avl_write,
  output logic        avl_read,
  output logic [63:0] avl_writedata,
  output logic        avl_beginbursttransfer,
  output logic [3:0]  avl_burstcount,
  output logic [7:0]  avl_byteenable,
  input  logic        avl_ready,
  input  logic [63:0] avl_readdata,
  input  logic        avl_readdatavalid
);

  localparam int TMR_W  = $clog2(RD_TIMEOUT + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [3:0]        STREAK_MAX = 4'(WR_MAX);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(RD_TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_B0,
    ST_WR_B1,
    ST_RD_CMD,
    ST_RD_WAIT
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         streak, streak_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [BEAT_W-1:0]  beat, beat_nxt;

  logic [24:0] address_nxt;
  logic        write_nxt, read_nxt, bbt_nxt;
  logic [63:0] writedata_nxt;
  logic        wr_ack_nxt, rd_ack_nxt, rd_valid_nxt, rd_done_nxt, rd_err_nxt;
  logic [63:0] rd_data_nxt;
  logic        grant_rd;
  logic        last_beat;

  // Burst shape is fixed; report nothing until calibration is done.
  assign avl_burstcount = init_done ? 4'(BURST_LEN) : 4'd0;
  assign avl_byteenable = init_done ? 8'hFF : 8'h00;

  // Read wins only when writes are idle or the write streak hit its cap.
  assign grant_rd  = rd_req & (~wr_req | (streak >= STREAK_MAX));
  assign last_beat = avl_readdatavalid & (beat == BEAT_LAST);

  always_comb begin
    state_nxt     = state;
    streak_nxt    = streak;
    tmr_nxt       = tmr;
    beat_nxt      = beat;
    address_nxt   = avl_address;
    write_nxt     = avl_write;
    read_nxt      = avl_read;
    bbt_nxt       = avl_beginbursttransfer;
    writedata_nxt = avl_writedata;
    rd_data_nxt   = rd_data;
    wr_ack_nxt    = 1'b0;
    rd_ack_nxt    = 1'b0;
    rd_valid_nxt  = 1'b0;
    rd_done_nxt   = 1'b0;
    rd_err_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rd_req) streak_nxt = 4'd0;
        if (enable && init_done) begin
          if (grant_rd) begin
            state_nxt   = ST_RD_CMD;
            read_nxt    = 1'b1;
            bbt_nxt     = 1'b1;
            address_nxt = rd_addr;
            streak_nxt  = 4'd0;
          end else if (wr_req) begin
            state_nxt     = ST_WR_B0;
            write_nxt     = 1'b1;
            bbt_nxt       = 1'b1;
            address_nxt   = wr_addr;
            writedata_nxt = wr_data0;
            if (rd_req)
              streak_nxt = (streak >= STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
          end
        end
      end

      ST_WR_B0: begin
        if (avl_ready) begin
          state_nxt     = ST_WR_B1;
          bbt_nxt       = 1'b0;
          writedata_nxt = wr_data1;
        end
      end

      ST_WR_B1: begin
        if (avl_ready) begin
          state_nxt     = ST_IDLE;
          write_nxt     = 1'b0;
          writedata_nxt = 64'd0;
          wr_ack_nxt    = 1'b1;
        end
      end

      ST_RD_CMD: begin
        if (avl_ready) begin
          state_nxt  = ST_RD_WAIT;
          read_nxt   = 1'b0;
          bbt_nxt    = 1'b0;
          rd_ack_nxt = 1'b1;
          tmr_nxt    = '0;
          beat_nxt   = '0;
        end
      end

      ST_RD_WAIT: begin
        if (avl_readdatavalid) begin
          rd_data_nxt  = avl_readdata;
          rd_valid_nxt = 1'b1;
          beat_nxt     = beat + 1'b1;
        end
        if (last_beat) begin
          rd_done_nxt = 1'b1;
          beat_nxt    = '0;
          state_nxt   = ST_IDLE;
        end else if (tmr == TMR_LAST) begin
          // A final beat on the timeout cycle still counts as completion.
          rd_err_nxt = 1'b1;
          beat_nxt   = '0;
          state_nxt  = ST_IDLE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      streak                 <= 4'd0;
      tmr                    <= '0;
      beat                   <= '0;
      avl_address            <= 25'd0;
      avl_write              <= 1'b0;
      avl_read               <= 1'b0;
      avl_beginbursttransfer <= 1'b0;
      avl_writedata          <= 64'd0;
      rd_data                <= 64'd0;
      wr_ack                 <= 1'b0;
      rd_ack                 <= 1'b0;
      rd_valid               <= 1'b0;
      rd_done                <= 1'b0;
      rd_err                 <= 1'b0;
    end else begin
      state                  <= state_nxt;
      streak                 <= streak_nxt;
      tmr                    <= tmr_nxt;
      beat                   <= beat_nxt;
      avl_address            <= address_nxt;
      avl_write              <= write_nxt;
      avl_read               <= read_nxt;
      avl_beginbursttransfer <= bbt_nxt;
      avl_writedata          <= writedata_nxt;
      rd_data                <= rd_data_nxt;
      wr_ack                 <= wr_ack_nxt;
      rd_ack                 <= rd_ack_nxt;
      rd_valid               <= rd_valid_nxt;
      rd_done                <= rd_done_nxt;
      rd_err                 <= rd_err_nxt;
    end
  end

endmodule

// File: tb/tb_ddr_avl_arbiter.sv
// Testbench for ddr_avl_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all continuously compared against a
// transaction-level model of the arbiter.
module tb_ddr_avl_arbiter;

  localparam int WR_MAX     = 8;
  localparam int RD_TIMEOUT = 16;
  localparam int BURST_LEN  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, init_done = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [24:0] wr_addr = '0, rd_addr = '0;
  logic [63:0] wr_data0 = '0, wr_data1 = '0;
  logic        avl_ready = 1'b0, avl_readdatavalid = 1'b0;
  logic [63:0] avl_readdata = '0;
  logic        wr_ack, rd_ack, rd_valid, rd_done, rd_err;
  logic [63:0] rd_data;
  logic [24:0] avl_address;
  logic        avl_write, avl_read, avl_beginbursttransfer;
  logic [63:0] avl_writedata;
  logic [3:0]  avl_burstcount;
  logic [7:0]  avl_byteenable;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ddr_avl_arbiter #(.WR_MAX(WR_MAX), .RD_TIMEOUT(RD_TIMEOUT), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done), .rd_err(rd_err),
    .avl_address(avl_address), .avl_write(avl_write), .avl_read(avl_read),
    .avl_writedata(avl_writedata), .avl_beginbursttransfer(avl_beginbursttransfer),
    .avl_burstcount(avl_burstcount), .avl_byteenable(avl_byteenable),
    .avl_ready(avl_ready), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // job: 0 none, 1 write burst, 2 read burst
  int          m_job, m_beats, m_elapsed, m_streak;
  bit          m_cmd_open;
  logic        m_write, m_read, m_bbt, m_wr_ack, m_rd_ack, m_rd_valid, m_rd_done, m_rd_err;
  logic [24:0] m_addr;
  logic [63:0] m_wdata, m_rd_data;

  task automatic model_reset();
    m_job = 0; m_beats = 0; m_elapsed = 0; m_streak = 0; m_cmd_open = 0;
    m_write = 0; m_read = 0; m_bbt = 0; m_wr_ack = 0; m_rd_ack = 0;
    m_rd_valid = 0; m_rd_done = 0; m_rd_err = 0;
    m_addr = '0; m_wdata = '0; m_rd_data = '0;
  endtask

  task automatic model_step();
    m_wr_ack = 0; m_rd_ack = 0; m_rd_valid = 0; m_rd_done = 0; m_rd_err = 0;
    if (m_job == 0) begin
      bit read_turn;
      read_turn = rd_req && (!wr_req || m_streak >= WR_MAX);
      if (!rd_req) m_streak = 0;
      if (enable && init_done) begin
        if (read_turn) begin
          m_job = 2; m_cmd_open = 1; m_streak = 0;
          m_read = 1; m_bbt = 1; m_addr = rd_addr;
        end else if (wr_req) begin
          m_job = 1; m_beats = 0;
          m_write = 1; m_bbt = 1; m_addr = wr_addr; m_wdata = wr_data0;
          if (rd_req && m_streak < WR_MAX) m_streak++;
        end
      end
    end else if (m_job == 1) begin
      if (avl_ready) begin
        m_beats++;
        if (m_beats < BURST_LEN) begin
          m_bbt = 0; m_wdata = wr_data1;
        end else begin
          m_write = 0; m_wdata = '0; m_wr_ack = 1; m_job = 0;
        end
      end
    end else if (m_cmd_open) begin
      if (avl_ready) begin
        m_cmd_open = 0; m_read = 0; m_bbt = 0; m_rd_ack = 1;
        m_elapsed = 0; m_beats = 0;
      end
    end else begin
      if (avl_readdatavalid) begin
        m_rd_data = avl_readdata; m_rd_valid = 1; m_beats++;
      end
      m_elapsed++;
      if (avl_readdatavalid && m_beats == BURST_LEN) begin
        m_rd_done = 1; m_job = 0;
      end else if (m_elapsed >= RD_TIMEOUT) begin
        m_rd_err = 1; m_job = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // One compare per cycle, shortly after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("avl_write", 64'(avl_write), 64'(m_write));
      chk("avl_read", 64'(avl_read), 64'(m_read));
      chk("avl_bbt", 64'(avl_beginbursttransfer), 64'(m_bbt));
      chk("wr_ack", 64'(wr_ack), 64'(m_wr_ack));
      chk("rd_ack", 64'(rd_ack), 64'(m_rd_ack));
      chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
      chk("rd_done", 64'(rd_done), 64'(m_rd_done));
      chk("rd_err", 64'(rd_err), 64'(m_rd_err));
      chk("avl_burstcount", 64'(avl_burstcount), init_done ? 64'd2 : 64'd0);
      chk("avl_byteenable", 64'(avl_byteenable), init_done ? 64'hFF : 64'h0);
      if (m_write || m_read) chk("avl_address", 64'(avl_address), 64'(m_addr));
      if (m_write) chk("avl_writedata", avl_writedata, m_wdata);
      if (m_rd_valid) chk("rd_data", rd_data, m_rd_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int grants[$];
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_avl_write", 64'(avl_write), 64'd0);
    chk("rst_wr_ack", 64'(wr_ack), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_burstcount", 64'(avl_burstcount), 64'd0);
    chk("rst_byteenable", 64'(avl_byteenable), 64'd0);
    rst_n = 1'b1;

    // Single write burst
    @(negedge clk);
    init_done = 1; enable = 1; avl_ready = 1;
    wr_addr = 25'h10; wr_data0 = 64'hA5A5_A5A5_A5A5_A5A5; wr_data1 = 64'h5A5A_5A5A_5A5A_5A5A;
    wr_req = 1;
    @(negedge clk);
    chk("t1_b0_write", 64'(avl_write), 64'd1);
    chk("t1_b0_bbt", 64'(avl_beginbursttransfer), 64'd1);
    chk("t1_b0_addr", 64'(avl_address), 64'h10);
    chk("t1_b0_data", avl_writedata, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_burstcount", 64'(avl_burstcount), 64'd2);
    @(negedge clk);
    chk("t1_b1_write", 64'(avl_write), 64'd1);
    chk("t1_b1_bbt", 64'(avl_beginbursttransfer), 64'd0);
    chk("t1_b1_data", avl_writedata, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("t1_b1_ack", 64'(wr_ack), 64'd0);
    @(negedge clk);
    chk("t1_ack", 64'(wr_ack), 64'd1);
    chk("t1_ack_write", 64'(avl_write), 64'd0);
    wr_req = 0;
    @(negedge clk);
    chk("t1_ack_pulse", 64'(wr_ack), 64'd0);

    // Single read burst, beats return 5 cycles after accept
    rd_addr = 25'hC80; rd_req = 1;
    @(negedge clk);
    chk("t2_read", 64'(avl_read), 64'd1);
    chk("t2_bbt", 64'(avl_beginbursttransfer), 64'd1);
    chk("t2_addr", 64'(avl_address), 64'hC80);
    @(negedge clk);
    chk("t2_rd_ack", 64'(rd_ack), 64'd1);
    chk("t2_read_drop", 64'(avl_read), 64'd0);
    rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_no_valid", 64'(rd_valid), 64'd0);
      chk("t2_rd_ack_once", 64'(rd_ack), 64'd0);
    end
    avl_readdatavalid = 1; avl_readdata = 64'h1111_1111_1111_1111;
    @(negedge clk);
    avl_readdata = 64'h2222_2222_2222_2222;
    chk("t2_v0", 64'(rd_valid), 64'd1);
    chk("t2_d0", rd_data, 64'h1111_1111_1111_1111);
    chk("t2_done0", 64'(rd_done), 64'd0);
    @(negedge clk);
    avl_readdatavalid = 0;
    chk("t2_v1", 64'(rd_valid), 64'd1);
    chk("t2_d1", rd_data, 64'h2222_2222_2222_2222);
    chk("t2_done1", 64'(rd_done), 64'd1);
    @(negedge clk);
    chk("t2_done_pulse", 64'(rd_done), 64'd0);

    // Both requesters held: 8 writes then 1 read, repeated
    wr_req = 1; rd_req = 1; avl_readdatavalid = 1; avl_readdata = 64'h3333;
    for (int c = 0; c < 300 && grants.size() < 18; c++) begin
      @(negedge clk);
      if (avl_beginbursttransfer) grants.push_back(avl_write ? 1 : 2);
    end
    wr_req = 0; rd_req = 0;
    chk("t3_grant_count", 64'(grants.size()), 64'd18);
    for (int i = 0; i < grants.size(); i++)
      chk("t3_grant_kind", 64'(grants[i]), (i % 9 == 8) ? 64'd2 : 64'd1);
    repeat (5) @(negedge clk);
    avl_readdatavalid = 0;
    @(negedge clk);

    // avl_ready stalls beat 1 for 4 cycles
    wr_addr = 25'h1ABCD; wr_data0 = 64'h0123_4567_89AB_CDEF; wr_data1 = 64'hFEDC_BA98_7654_3210;
    wr_req = 1;
    @(negedge clk);
    chk("t4_b0", 64'(avl_beginbursttransfer), 64'd1);
    @(negedge clk);
    avl_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_hold_write", 64'(avl_write), 64'd1);
      chk("t4_hold_data", avl_writedata, 64'hFEDC_BA98_7654_3210);
      chk("t4_no_ack", 64'(wr_ack), 64'd0);
    end
    avl_ready = 1;
    @(negedge clk);
    chk("t4_ack", 64'(wr_ack), 64'd1);
    wr_req = 0;
    @(negedge clk);

    // Read timeout: rd_err 16 cycles after rd_ack, then a write is granted
    rd_addr = 25'h777; rd_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_rd_ack", 64'(rd_ack), 64'd1);
    rd_req = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("t5_rd_err", 64'(rd_err), (i == 16) ? 64'd1 : 64'd0);
    end
    wr_addr = 25'h55; wr_req = 1;
    @(negedge clk);
    chk("t5_write_after_err", 64'(avl_write), 64'd1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (wr_ack) seen = 1;
    end
    wr_req = 0;
    chk("t5_wr_ack_seen", 64'(seen), 64'd1);

    // Reset during RD_WAIT, stray beat afterwards
    rd_addr = 25'h900; rd_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rd_ack", 64'(rd_ack), 64'd1);
    rd_req = 0; avl_readdatavalid = 1; avl_readdata = 64'hDEAD_BEEF;
    @(negedge clk);
    avl_readdatavalid = 0;
    chk("t6_valid_before_rst", 64'(rd_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_valid", 64'(rd_valid), 64'd0);
    chk("t6_rst_data", rd_data, 64'd0);
    chk("t6_rst_read", 64'(avl_read), 64'd0);
    @(negedge clk);
    rst_n = 1; avl_readdatavalid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_stray_valid", 64'(rd_valid), 64'd0);
    end
    avl_readdatavalid = 0;

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 499) == 0) rst_n = 0;
      enable       = ($urandom_range(0, 15) != 0);
      init_done    = ($urandom_range(0, 15) != 0);
      wr_req       = ($urandom_range(0, 2) != 0);
      rd_req       = ($urandom_range(0, 1) != 0);
      wr_addr      = 25'($urandom);
      rd_addr      = 25'($urandom);
      wr_data0     = {$urandom, $urandom};
      wr_data1     = {$urandom, $urandom};
      avl_ready    = ($urandom_range(0, 3) != 0);
      avl_readdatavalid = ($urandom_range(0, 9) < 4);
      avl_readdata = {$urandom, $urandom};
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_avl_arbiter.md
Name: ddr_avl_arbiter

Overview:
- Shares the single DDR3 Avalon-MM user port (25-bit address, 64-bit data, 2-beat bursts) between two requesters.
- The write requester is the ADC sample/timestamp logger: one 2-beat burst per sample.
- The read requester is the alarm pre/post readback engine.
- Writes have priority so sample data is never dropped; a starvation guard forces a read grant after WR_MAX consecutive writes. Sits between the logger/readback engines and the memory controller.

Parameters:
- WR_MAX, 8, consecutive write bursts granted while rd_req is pending before a read is forced.
- RD_TIMEOUT, 1023, cycles allowed from read command acceptance to last readdatavalid beat.
- BURST_LEN, 2, beats per burst; fixed; drives avl_burstcount.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  arbitration enable; sampled only in IDLE
- init_done  in  1  memory calibration complete; no grants while low
- wr_req  in  1  write burst request; hold with addr/data until wr_ack
- wr_addr  in  25  write burst base address
- wr_data0  in  64  beat 0 (timestamp word)
- wr_data1  in  64  beat 1 (ADC channel word)
- wr_ack  out  1  1-cycle pulse: beat 1 accepted
- rd_req  in  1  read burst request; hold with addr until rd_ack
- rd_addr  in  25  read burst base address
- rd_ack  out  1  1-cycle pulse: read command accepted
- rd_data  out  64  returned beat
- rd_valid  out  1  rd_data valid, one cycle per beat
- rd_done  out  1  pulse with final beat
- rd_err  out  1  pulse on read timeout
- avl_address  out  25  Avalon address
- avl_write  out  1  Avalon write
- avl_read  out  1  Avalon read
- avl_writedata  out  64  Avalon write data
- avl_beginbursttransfer  out  1  Avalon burst start
- avl_burstcount  out  4  BURST_LEN while init_done, else 0
- avl_byteenable  out  8  8'hFF while init_done, else 0
- avl_ready  in  1  controller ready (active-high, inverse of waitrequest)
- avl_readdata  in  64  Avalon read data
- avl_readdatavalid  in  1  Avalon read data valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registered outputs 0; streak and timeout counters 0. Applies mid-burst; no burst completion is attempted.
- Clean handshake: only one burst is ever outstanding, and requesters see only wr_ack/rd_ack/rd_done/rd_err pulses.
- States: IDLE, WR_B0, WR_B1, RD_CMD, RD_WAIT.
- IDLE, grant rule, when enable&init_done:
  - rd_req & (~wr_req | streak>=WR_MAX) -> RD_CMD.
  - else wr_req -> WR_B0.
  - else stay in IDLE.
- Grant registration: the next cycle presents the command (registered, 1-cycle grant latency).
- WR_B0: avl_write=1, avl_beginbursttransfer=1, avl_address=wr_addr, avl_writedata=wr_data0; held unchanged while avl_ready=0. On avl_ready=1 -> WR_B1.
- WR_B1: avl_write=1, beginbursttransfer=0, writedata=wr_data1; held while avl_ready=0. On avl_ready=1: wr_ack=1 next cycle, avl_write=0, avl_writedata=0, -> IDLE.
- RD_CMD: avl_read=1, beginbursttransfer=1, avl_address=rd_addr, held until avl_ready=1. Then avl_read=0, rd_ack pulse, timeout counter cleared, -> RD_WAIT.
- RD_WAIT:
  - Each avl_readdatavalid: rd_data<=avl_readdata, rd_valid=1 next cycle; beat counter increments.
  - On beat BURST_LEN: rd_done pulses with that rd_valid, -> IDLE.
  - If the counter reaches RD_TIMEOUT first: rd_err pulse, -> IDLE. Late beats are then ignored.
- Streak counter (4-bit, saturating at WR_MAX):
  - +1 on each write grant while rd_req=1.
  - Cleared on read grant or when rd_req=0 in IDLE.
- Simultaneous wr_req and rd_req with streak<WR_MAX: write wins.
- avl_readdatavalid outside RD_WAIT: ignored; rd_valid stays 0.
- enable or init_done falling mid-burst: the current burst completes normally; no new grant.
- wr_req dropped before wr_ack: protocol violation. The arbiter still finishes the burst using the current input values.
- Back-to-back: IDLE is visited for exactly one cycle between bursts. Maximum throughput is one 2-beat write per 3 cycles with avl_ready=1.

Test Plan:
- Reset then init_done=1, enable=1, wr_req with addr=0x10, data0=0xA5.., data1=0x5A.., avl_ready=1 -> avl_write high 2 cycles, beginburst on beat 0 only, address 0x10, wr_ack 1 cycle after beat 1.
- rd_req addr=0xC80; controller returns beats 0x1111.. and 0x2222.. 5 cycles after accept -> rd_ack once, two rd_valid pulses with matching data, rd_done on second.
- wr_req and rd_req held high continuously, WR_MAX=8 -> exactly 8 write bursts, then 1 read, then the pattern repeats.
- avl_ready low 4 cycles during WR_B1 -> writedata=data1 and avl_write stable throughout; wr_ack only after ready.
- Read with no readdatavalid, RD_TIMEOUT=16 -> rd_err pulse 16 cycles after rd_ack; return to IDLE; a subsequent write is granted.
- rst_n asserted during RD_WAIT -> all outputs 0 immediately; stray readdatavalid after release produces no rd_valid.
